fsm_table_engine: RTL and testbench

- Runtime sequencer for table-driven state machines built on the fsm_pkg transition model; each (state, input) entry holds enable, priority and next state.
- The engine stores the table in an internal RAM, loaded through a config write port, and evaluates one transition per step request.
- Each evaluation scans one input per cycle instead of resolving all inputs combinationally. The highest-priority enabled, asserted input selects the next state.
- Sits between the control-plane register block (table load) and the datapath sequencer it drives (state_o).

---
 rtl/fsm_table_engine_if.sv | 42 ++++
 rtl/fsm_table_engine.sv | 194 +++++++++++++++++++
 tb/tb_fsm_table_engine.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_table_engine_if.sv
// Config, step and status bundle for fsm_table_engine; the engine sits on the slave side.
interface fsm_table_engine_if #(
  parameter int N_STATES = 16,
  parameter int N_INPUTS = 16,
  parameter int PW       = 8
);
  localparam int SW = $clog2(N_STATES);
  localparam int IW = $clog2(N_INPUTS);

  logic                run_i;
  logic                clr_i;
  logic                cfg_we_i;
  logic [SW-1:0]       cfg_state_i;
  logic [IW-1:0]       cfg_input_i;
  logic                cfg_en_i;
  logic [PW-1:0]       cfg_prio_i;
  logic [SW-1:0]       cfg_next_i;
  logic                cfg_ready_o;
  logic                cfg_err_o;
  logic                step_valid_i;
  logic                step_ready_o;
  logic [N_INPUTS-1:0] sig_i;
  logic [SW-1:0]       state_o;
  logic                done_o;
  logic                hit_o;
  logic [IW-1:0]       hit_input_o;
  logic                busy_o;

  modport slave (
    input  run_i, clr_i, cfg_we_i, cfg_state_i, cfg_input_i, cfg_en_i,
           cfg_prio_i, cfg_next_i, step_valid_i, sig_i,
    output cfg_ready_o, cfg_err_o, step_ready_o, state_o, done_o, hit_o,
           hit_input_o, busy_o
  );

  modport master (
    output run_i, clr_i, cfg_we_i, cfg_state_i, cfg_input_i, cfg_en_i,
           cfg_prio_i, cfg_next_i, step_valid_i, sig_i,
    input  cfg_ready_o, cfg_err_o, step_ready_o, state_o, done_o, hit_o,
           hit_input_o, busy_o
  );
endinterface

// File: rtl/fsm_table_engine.sv
// Table-driven state sequencer: RAM of {en, prio, next} per (state, input),
// resolved by a one-input-per-cycle priority scan.
module fsm_table_engine #(
  parameter int N_STATES   = 16,
  parameter int N_INPUTS   = 16,
  parameter int PW         = 8,
  parameter int INIT_STATE = 0
) (
  input logic               clk,
  input logic               rst_n,
  fsm_table_engine_if.slave bus
);
  localparam int SW    = $clog2(N_STATES);
  localparam int IW    = $clog2(N_INPUTS);
  localparam int DEPTH = N_STATES * N_INPUTS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = 1 + PW + SW;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_READY, S_SCAN, S_COMMIT} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       state_q, state_d;
  logic [N_INPUTS-1:0] snap_q, snap_d;
  logic [PW-1:0]       best_prio_q, best_prio_d;
  logic [SW-1:0]       best_next_q, best_next_d;
  logic [IW-1:0]       best_idx_q, best_idx_d;
  logic                best_hit_q, best_hit_d;
  logic                done_q, done_d;
  logic                hit_q, hit_d;
  logic [IW-1:0]       hit_idx_q, hit_idx_d;
  logic                err_q, err_d;

  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       rd_q;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [EW-1:0]       mem_wdata;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       cfg_addr;
  logic                cfg_in_range;
  logic                accept;
  logic                scan_last;
  logic [IW-1:0]       cmp_idx;
  logic                cand;
  logic                cfg_ready, step_ready, busy;

  assign cfg_in_range = (int'(bus.cfg_state_i) < N_STATES) && (int'(bus.cfg_input_i) < N_INPUTS);
  assign cfg_addr     = AW'(int'(bus.cfg_state_i) * N_INPUTS + int'(bus.cfg_input_i));
  assign rd_addr      = AW'(int'(state_q) * N_INPUTS + int'(cnt_q));
  assign accept       = (fsm_q == S_READY) && bus.step_valid_i;
  assign scan_last    = (cnt_q == CW'(N_INPUTS));
  // Read data lags the issued address by one cycle, so the entry under compare is cnt-1.
  assign cmp_idx      = IW'(cnt_q - CW'(1));
  assign cand         = rd_q[EW-1] && snap_q[cmp_idx] && (rd_q[PW+SW-1:SW] > best_prio_q);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= S_INIT;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_INIT:   if (cnt_q == CW'(DEPTH - 1)) fsm_d = S_IDLE;
      S_IDLE:   if (bus.run_i) fsm_d = S_READY;
      S_READY:  if (accept) fsm_d = S_SCAN;
                else if (!bus.run_i) fsm_d = S_IDLE;
      S_SCAN:   if (bus.clr_i) fsm_d = bus.run_i ? S_READY : S_IDLE;
                else if (scan_last) fsm_d = S_COMMIT;
      S_COMMIT: fsm_d = bus.run_i ? S_READY : S_IDLE;
      default:  fsm_d = S_INIT;
    endcase
  end

  always_comb begin
    cfg_ready  = 1'b0;
    step_ready = 1'b0;
    busy       = 1'b0;
    unique case (fsm_q)
      S_IDLE:  cfg_ready  = 1'b1;
      S_READY: step_ready = 1'b1;
      default: busy       = 1'b1;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    state_d     = state_q;
    snap_d      = snap_q;
    best_prio_d = best_prio_q;
    best_next_d = best_next_q;
    best_idx_d  = best_idx_q;
    best_hit_d  = best_hit_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    err_d       = bus.cfg_we_i && !((fsm_q == S_IDLE) && cfg_in_range);
    mem_we      = 1'b0;
    mem_waddr   = cnt_q[AW-1:0];
    mem_wdata   = '0;
    unique case (fsm_q)
      S_INIT: begin
        mem_we = 1'b1;
        cnt_d  = (cnt_q == CW'(DEPTH - 1)) ? '0 : cnt_q + CW'(1);
      end
      S_IDLE: begin
        if (bus.cfg_we_i && cfg_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = cfg_addr;
          mem_wdata = {bus.cfg_en_i, bus.cfg_prio_i, bus.cfg_next_i};
        end
        if (bus.clr_i) state_d = SW'(INIT_STATE);
      end
      S_READY: begin
        if (bus.clr_i) state_d = SW'(INIT_STATE);
        if (accept) begin
          snap_d      = bus.sig_i;
          best_prio_d = '0;
          best_hit_d  = 1'b0;
          cnt_d       = '0;
        end
      end
      S_SCAN: begin
        if (bus.clr_i) begin
          state_d = SW'(INIT_STATE);
        end else begin
          cnt_d = cnt_q + CW'(1);
          if ((cnt_q != '0) && cand) begin
            best_prio_d = rd_q[PW+SW-1:SW];
            best_next_d = rd_q[SW-1:0];
            best_idx_d  = cmp_idx;
            best_hit_d  = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        done_d    = 1'b1;
        hit_idx_d = best_idx_q;
        if (bus.clr_i) begin
          state_d = SW'(INIT_STATE);
          hit_d   = 1'b0;
        end else begin
          hit_d = best_hit_q;
          if (best_hit_q) state_d = best_next_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_q     <= SW'(INIT_STATE);
      snap_q      <= '0;
      best_prio_q <= '0;
      best_next_q <= '0;
      best_idx_q  <= '0;
      best_hit_q  <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      snap_q      <= snap_d;
      best_prio_q <= best_prio_d;
      best_next_q <= best_next_d;
      best_idx_q  <= best_idx_d;
      best_hit_q  <= best_hit_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      err_q       <= err_d;
    end
  end

  assign bus.cfg_ready_o  = cfg_ready;
  assign bus.step_ready_o = step_ready;
  assign bus.busy_o       = busy;
  assign bus.cfg_err_o    = err_q;
  assign bus.state_o      = state_q;
  assign bus.done_o       = done_q;
  assign bus.hit_o        = hit_q;
  assign bus.hit_input_o  = hit_idx_q;
endmodule

// File: tb/tb_fsm_table_engine.sv
// Directed bench for fsm_table_engine: 16x16 main instance plus a 16x12 instance for range guards.
module tb_fsm_table_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_table_engine_if #(.N_STATES(16), .N_INPUTS(16), .PW(8)) bus ();
  fsm_table_engine_if #(.N_STATES(16), .N_INPUTS(12), .PW(8)) bus12 ();

  fsm_table_engine #(.N_STATES(16), .N_INPUTS(16), .PW(8), .INIT_STATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  fsm_table_engine #(.N_STATES(16), .N_INPUTS(12), .PW(8), .INIT_STATE(0)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12.slave));

  typedef struct {
    logic [15:0] sig;
    int          hit;
    int          idx;
    int          nxt;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cfg_wr(input int s, input int i, input int en, input int pr, input int nx,
                        output logic err);
    bus.cfg_state_i = 4'(s);
    bus.cfg_input_i = 4'(i);
    bus.cfg_en_i    = en[0];
    bus.cfg_prio_i  = 8'(pr);
    bus.cfg_next_i  = 4'(nx);
    bus.cfg_we_i    = 1'b1;
    tick();
    err = bus.cfg_err_o;
    bus.cfg_we_i = 1'b0;
  endtask

  task automatic do_step(input logic [15:0] s, output int lat, output logic hit,
                         output int idx, output int st);
    bus.sig_i        = s;
    bus.step_valid_i = 1'b1;
    tick();
    bus.step_valid_i = 1'b0;
    bus.sig_i        = ~s;
    lat = 0;
    while (!bus.done_o && lat < 40) begin
      tick();
      lat++;
    end
    hit = bus.hit_o;
    idx = int'(bus.hit_input_o);
    st  = int'(bus.state_o);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (bus.busy_o && n < 1000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int   lat, idx, st, n, dn, errs;
    logic hit, err;

    vecs[0] = '{16'h0284, 1, 7,  4};
    vecs[1] = '{16'h8002, 1, 15, 8};
    vecs[2] = '{16'h0018, 1, 4,  0};
    vecs[3] = '{16'h0001, 0, 0,  0};
    vecs[4] = '{16'h0204, 1, 9,  6};
    vecs[5] = '{16'hFFDF, 0, 0,  6};
    vecs[6] = '{16'h0020, 1, 5,  0};
    vecs[7] = '{16'h0004, 1, 2,  3};
    vecs[8] = '{16'h0001, 1, 0,  0};
    vecs[9] = '{16'h0000, 0, 0,  0};

    bus.run_i = 0; bus.clr_i = 0; bus.cfg_we_i = 0; bus.cfg_state_i = 0; bus.cfg_input_i = 0;
    bus.cfg_en_i = 0; bus.cfg_prio_i = 0; bus.cfg_next_i = 0; bus.step_valid_i = 0; bus.sig_i = 0;
    bus12.run_i = 0; bus12.clr_i = 0; bus12.cfg_we_i = 0; bus12.cfg_state_i = 0; bus12.cfg_input_i = 0;
    bus12.cfg_en_i = 0; bus12.cfg_prio_i = 0; bus12.cfg_next_i = 0; bus12.step_valid_i = 0; bus12.sig_i = 0;

    // Reset values, then the init sweep length
    tick(); tick();
    chk("rst busy", int'(bus.busy_o), 1);
    chk("rst cfg_ready", int'(bus.cfg_ready_o), 0);
    chk("rst step_ready", int'(bus.step_ready_o), 0);
    chk("rst done", int'(bus.done_o), 0);
    chk("rst state", int'(bus.state_o), 0);
    rst_n = 1'b1;
    wait_init(n);
    chk("init busy cycles", n, 256);
    chk("init cfg_ready", int'(bus.cfg_ready_o), 1);
    chk("init state", int'(bus.state_o), 0);

    // Range guard on the 12-input instance, then one evaluation on it
    bus12.cfg_state_i = 4'd0; bus12.cfg_input_i = 4'd13; bus12.cfg_en_i = 1'b1;
    bus12.cfg_prio_i = 8'd1; bus12.cfg_next_i = 4'd9; bus12.cfg_we_i = 1'b1;
    tick();
    chk("n12 input13 err", int'(bus12.cfg_err_o), 1);
    bus12.cfg_input_i = 4'd11; bus12.cfg_next_i = 4'd2;
    tick();
    chk("n12 input11 err", int'(bus12.cfg_err_o), 0);
    bus12.cfg_we_i = 1'b0;
    bus12.run_i = 1'b1;
    tick();
    bus12.sig_i = 12'hA00; bus12.step_valid_i = 1'b1;
    tick();
    bus12.step_valid_i = 1'b0;
    n = 0;
    while (!bus12.done_o && n < 40) begin tick(); n++; end
    chk("n12 latency", n, 14);
    chk("n12 state", int'(bus12.state_o), 2);
    chk("n12 idx", int'(bus12.hit_input_o), 11);

    // Empty table: all inputs asserted must not hit
    bus.run_i = 1'b1;
    tick();
    do_step(16'hFFFF, lat, hit, idx, st);
    chk("empty latency", lat, 18);
    chk("empty hit", int'(hit), 0);
    chk("empty state", st, 0);

    bus.run_i = 1'b0;
    tick();
    chk("idle cfg_ready", int'(bus.cfg_ready_o), 1);
    errs = 0;
    cfg_wr(0, 2,  1, 5,   3, err); errs += int'(err);
    cfg_wr(0, 7,  1, 9,   4, err); errs += int'(err);
    cfg_wr(0, 9,  1, 9,   6, err); errs += int'(err);
    cfg_wr(0, 0,  1, 0,   5, err); errs += int'(err);
    cfg_wr(4, 1,  1, 3,   0, err); errs += int'(err);
    cfg_wr(4, 15, 1, 200, 8, err); errs += int'(err);
    cfg_wr(8, 3,  0, 50,  2, err); errs += int'(err);
    cfg_wr(8, 4,  1, 1,   0, err); errs += int'(err);
    cfg_wr(6, 5,  1, 7,   0, err); errs += int'(err);
    cfg_wr(3, 0,  1, 255, 0, err); errs += int'(err);
    chk("idle write errs", errs, 0);

    bus.run_i = 1'b1;
    tick();
    chk("ready step_ready", int'(bus.step_ready_o), 1);
    for (int k = 0; k < 10; k++) begin
      do_step(vecs[k].sig, lat, hit, idx, st);
      chk($sformatf("vec%0d latency", k), lat, 18);
      chk($sformatf("vec%0d hit", k), int'(hit), vecs[k].hit);
      if (vecs[k].hit != 0) chk($sformatf("vec%0d idx", k), idx, vecs[k].idx);
      chk($sformatf("vec%0d state", k), st, vecs[k].nxt);
    end

    // Write attempted in READY is dropped
    cfg_wr(0, 2, 1, 250, 9, err);
    chk("ready write err", int'(err), 1);
    tick();
    chk("ready err pulse width", int'(bus.cfg_err_o), 0);
    do_step(16'h0004, lat, hit, idx, st);
    chk("table kept state", st, 3);
    do_step(16'h0001, lat, hit, idx, st);
    chk("back to 0", st, 0);

    // clr five cycles into a scan
    do_step(16'h0284, lat, hit, idx, st);
    chk("pre-clr state", st, 4);
    bus.sig_i = 16'h8002; bus.step_valid_i = 1'b1;
    tick();
    bus.step_valid_i = 1'b0;
    dn = 0;
    for (int k = 0; k < 5; k++) begin tick(); dn += int'(bus.done_o); end
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    for (int k = 0; k < 25; k++) begin dn += int'(bus.done_o); tick(); end
    chk("clr scan done count", dn, 0);
    chk("clr scan state", int'(bus.state_o), 0);
    chk("clr scan step_ready", int'(bus.step_ready_o), 1);

    // run_i dropped mid-scan
    bus.sig_i = 16'h0284; bus.step_valid_i = 1'b1;
    tick();
    bus.step_valid_i = 1'b0;
    tick(); tick(); tick();
    bus.run_i = 1'b0;
    n = 3;
    while (!bus.done_o && n < 40) begin tick(); n++; end
    chk("rundrop done", int'(bus.done_o), 1);
    chk("rundrop latency", n, 18);
    chk("rundrop state", int'(bus.state_o), 4);
    chk("rundrop step_ready", int'(bus.step_ready_o), 0);
    chk("rundrop cfg_ready", int'(bus.cfg_ready_o), 1);

    // Async reset in the middle of a scan
    bus.run_i = 1'b1;
    tick();
    bus.sig_i = 16'h8002; bus.step_valid_i = 1'b1;
    tick();
    bus.step_valid_i = 1'b0;
    tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst state", int'(bus.state_o), 0);
    chk("arst hit", int'(bus.hit_o), 0);
    chk("arst hit_input", int'(bus.hit_input_o), 0);
    chk("arst done", int'(bus.done_o), 0);
    chk("arst busy", int'(bus.busy_o), 1);
    chk("arst step_ready", int'(bus.step_ready_o), 0);
    chk("arst cfg_ready", int'(bus.cfg_ready_o), 0);
    bus.run_i = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_init(n);
    chk("reinit busy cycles", n, 256);
    chk("reinit cfg_ready", int'(bus.cfg_ready_o), 1);
    bus.run_i = 1'b1;
    tick();
    do_step(16'h0284, lat, hit, idx, st);
    chk("reinit latency", lat, 18);
    chk("reinit hit", int'(hit), 0);
    chk("reinit state", st, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
